// File: rtl/vram_fill_if.sv
// VRAM request/response bus between vram_fill (master) and the RAM controller (slave).
interface vram_fill_if;
  logic [14:0] vram_addr;
  logic [31:0] vram_data_in;
  logic        vram_req;
  logic        vram_write;
  logic        vram_done;
  logic        vram_ready;
  logic [31:0] vram_data_out;

  modport master (
    output vram_addr,
    output vram_data_in,
    output vram_req,
    output vram_write,
    input  vram_done,
    input  vram_ready,
    input  vram_data_out
  );

  modport slave (
    input  vram_addr,
    input  vram_data_in,
    input  vram_req,
    input  vram_write,
    output vram_done,
    output vram_ready,
    output vram_data_out
  );
endinterface

// File: rtl/vram_fill.sv
// Fills VRAM words 0..LAST_ADDR with a selectable pattern through a req/done controller.
// Define VRAM_FILL_READBACK_EN to add a verifying readback pass (error/err_addr live).
module vram_fill #(
  parameter int unsigned LAST_ADDR     = 24575,
  parameter int unsigned WORDS_PER_ROW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern,
  vram_fill_if.master       vram,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [14:0]       err_addr
);

  typedef enum logic [2:0] {
    IDLE,
    WREQ,
    WGAP,
    RREQ,
    RGAP,
    FIN
  } state_t;

  localparam logic [14:0] LAST = 15'(LAST_ADDR);
  localparam logic [14:0] WPR  = 15'(WORDS_PER_ROW);

  state_t      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [1:0]  pat_q, pat_d;
  logic        err_q, err_d;
  logic [14:0] err_addr_q, err_addr_d;
  logic        req_q, req_d;
  logic        write_q, write_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] word;

  function automatic logic [31:0] fill_word(input logic [1:0] pat, input logic [14:0] a);
    logic [14:0] row;
    logic [31:0] w;
    row = a / WPR;
    case (pat)
      2'd0:    w = '0;
      2'd1:    w = '1;
      2'd2:    w = row[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: w = {17'b0, a};
    endcase
    return w;
  endfunction

  // Same word serves as write data and as the readback expectation.
  assign word = fill_word(pat_q, addr_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pat_d      = pat_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d      = pattern;
          addr_d     = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
          state_d    = WREQ;
        end
      end
      WREQ: begin
        if (vram.vram_done) state_d = WGAP;
      end
      WGAP: begin
        if (addr_q == LAST) begin
`ifdef VRAM_FILL_READBACK_EN
          // Readback walks the whole range again from word 0.
          addr_d  = '0;
          state_d = RREQ;
`else
          state_d = FIN;
`endif
        end else begin
          addr_d  = addr_q + 15'd1;
          state_d = WREQ;
        end
      end
`ifdef VRAM_FILL_READBACK_EN
      RREQ: begin
        if (vram.vram_ready) begin
          if ((vram.vram_data_out != word) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
          end
          state_d = RGAP;
        end
      end
      RGAP: begin
        if (addr_q == LAST) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 15'd1;
          state_d = RREQ;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so nothing leaks combinationally from inputs.
    req_d   = (state_d == WREQ) || (state_d == RREQ);
    write_d = (state_d == WREQ);
    busy_d  = (state_d != IDLE) && (state_d != FIN);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pat_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      req_q      <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pat_q      <= pat_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      req_q      <= req_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifndef VRAM_FILL_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^{vram.vram_ready, vram.vram_data_out};
`endif

  assign vram.vram_addr    = addr_q;
  assign vram.vram_data_in = word;
  assign vram.vram_req     = req_q;
  assign vram.vram_write   = write_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;
  assign err_addr          = err_addr_q;

endmodule

// File: doc/vram_fill.md
VRAM_FILL -- requirements
Module: vram_fill

Interface
REQ-001 Parameter LAST_ADDR, default 24575: last VRAM word address written; 1024x768 mono at 32 pixels/word.
REQ-002 Parameter WORDS_PER_ROW, default 32: VRAM words per scan line.
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a fill; ignored while busy.
REQ-006 Port pattern, input, 2: fill pattern, sampled on accepted start.
REQ-007 Port vram_addr, output, 15: VRAM word address to ram_controller.
REQ-008 Port vram_data_in, output, 32: write data to ram_controller.
REQ-009 Port vram_req, output, 1: request to ram_controller.
REQ-010 Port vram_write, output, 1: 1 = write request, 0 = read request.
REQ-011 Port vram_done, input, 1: one-cycle write-complete strobe from ram_controller.
REQ-012 Port vram_ready, input, 1: one-cycle read-complete strobe; vram_data_out valid that cycle.
REQ-013 Port vram_data_out, input, 32: read data from ram_controller.
REQ-014 Port busy, output, 1: high from accepted start until done.
REQ-015 Port done, output, 1: one-cycle pulse when a fill (and readback, if built) completes.
REQ-016 Port error, output, 1: sticky readback-mismatch flag, cleared by next accepted start.
REQ-017 Port err_addr, output, 15: address of the first mismatch.

Function
REQ-018 States: IDLE, WREQ, WGAP, RREQ, RGAP, FIN.
REQ-019 IDLE: start=1 captures pattern, clears addr and error, goes to WREQ next cycle.
REQ-020 WREQ: vram_req=1, vram_write=1; addr/data held stable until vram_done=1.
REQ-021 vram_done in WREQ -> WGAP; vram_req low for exactly one cycle in WGAP.
REQ-022 WGAP: addr==LAST_ADDR -> RREQ (readback built) or FIN; otherwise addr+1 -> WREQ.
REQ-023 Data per pattern: 0 = 0x00000000; 1 = 0xFFFFFFFF; 2 = 0xAAAAAAAA on even rows and 0x55555555 on odd rows, where row = addr / WORDS_PER_ROW; 3 = {17'b0, addr}.
REQ-024 Write and read data are computed combinationally from the registered addr and pattern.
REQ-025 RREQ: vram_req=1, vram_write=0 until vram_ready=1; compare vram_data_out with the expected data in that cycle.
REQ-026 On a mismatch with error=0: set error and load err_addr=addr; later mismatches do not change err_addr.
REQ-027 RGAP mirrors WGAP: one idle cycle, then addr+1 -> RREQ, or addr==LAST_ADDR -> FIN.
REQ-028 FIN: done=1 for one cycle, then IDLE; busy=0 in FIN.
REQ-029 vram_done outside WREQ and vram_ready outside RREQ are ignored.
REQ-030 start while busy is ignored; the pattern register does not change.
REQ-031 Address counter is 15-bit; never increments past LAST_ADDR (no wrap).
REQ-032 vram_req is registered; no combinational path from any input to any output.

Reset
REQ-033 Reset forces IDLE, vram_addr=0, vram_data_in=0, vram_req=0, vram_write=0, busy=0, done=0, error=0, err_addr=0.
REQ-034 Reset mid-fill drops vram_req the same cycle (asynchronous); no pending request resumes after reset.

Configuration
REQ-035 Macro VRAM_FILL_READBACK_EN defined: RREQ/RGAP are implemented, error and err_addr are live.
REQ-036 Macro undefined: WGAP at LAST_ADDR goes straight to FIN; error and err_addr are held 0; vram_write=1 whenever vram_req=1.

Verification
REQ-037 pattern=1, controller done 2 cycles after req, LAST_ADDR=3 -> writes of 0xFFFFFFFF to addresses 0..3, one-cycle req gaps, one done pulse.
REQ-038 pattern=2, WORDS_PER_ROW=2, LAST_ADDR=5 -> data AAAAAAAA, AAAAAAAA, 55555555, 55555555, AAAAAAAA, AAAAAAAA.
REQ-039 Readback built, pattern=3, LAST_ADDR=7, model returns 0x00000000 at address 5 and address 6 -> error=1, err_addr=5, done pulses after address 7 is read.
REQ-040 Reset asserted in WREQ at address 10 -> vram_req=0 immediately, state IDLE, busy=0; new start restarts at address 0.
REQ-041 start pulsed at address 2 mid-fill with pattern changed 1->0 -> ignored; fill continues writing 0xFFFFFFFF.
REQ-042 Stray vram_done in IDLE and stray vram_ready in WREQ -> no state or address change.
